// File: rtl/rv32m_muldiv_if.sv
// Operand/result bundle between the core and the iterative RV32M mul/div unit.
// The slave side is the unit; the master side is the core (or a bench driver).
interface rv32m_muldiv_if;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic [1:0]  state_o;

    // Handshake: start_i is a request taken only while the unit is idle (busy_o=0,
    // done_o=0); operands and rd_i are captured on that edge. done_o is a one-cycle
    // pulse marking result_o/rd_o valid; they then hold until the next result.
    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, rd_i,
        output busy_o, done_o, result_o, rd_o, state_o
    );

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, rd_i,
        input  busy_o, done_o, result_o, rd_o, state_o
    );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up folded into the final step.
module rv32m_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    rv32m_muldiv_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [4:0]      rd_cap_q, rd_cap_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;

    // Operand decode at the start edge
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    always_comb begin
        is_div   = bus.funct3_i[2];
        a_sgn    = is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
        b_sgn    = is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
        a_neg    = a_sgn & bus.rs1_i[XLEN-1];
        b_neg    = b_sgn & bus.rs2_i[XLEN-1];
        a_mag    = a_neg ? (~bus.rs1_i + 32'd1) : bus.rs1_i;
        b_mag    = b_neg ? (~bus.rs2_i + 32'd1) : bus.rs2_i;
        div_zero = is_div & (bus.rs2_i == 32'd0);
        div_ovf  = is_div & ~bus.funct3_i[0] & (bus.rs1_i == 32'h8000_0000) &
                   (bus.rs2_i == 32'hFFFF_FFFF);
    end

    // One iteration of each datapath; the op selects which one is committed.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   mul_hi;
    logic [XLEN-1:0] mul_lo;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic [XLEN:0]   div_hi;
    logic [XLEN-1:0] div_lo;

    always_comb begin
        mul_sum   = lo_q[0] ? (hi_q + {1'b0, opb_q}) : hi_q;
        mul_hi    = {1'b0, mul_sum[XLEN:1]};
        mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
        div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        // Remainder stays below the divisor, so a kept trial never needs bit 32.
        if (!div_diff[XLEN+1]) begin
            div_hi = div_diff[XLEN:0];
            div_lo = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            div_hi = div_shift;
            div_lo = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    // Signed fix-up applied to the values produced by the last iteration
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        prod_mag = {mul_hi[XLEN-1:0], mul_lo};
        prod_fix = neg_q ? (~prod_mag + 64'd1) : prod_mag;
        quot_fix = neg_q ? (~div_lo + 32'd1) : div_lo;
        rem_fix  = rem_neg_q ? (~div_hi[XLEN-1:0] + 32'd1) : div_hi[XLEN-1:0];
        case (op_q)
            3'b000:  final_res = prod_fix[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100:  final_res = quot_fix;
            3'b101:  final_res = div_lo;
            3'b110:  final_res = rem_fix;
            default: final_res = div_hi[XLEN-1:0];
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        rd_cap_d  = rd_cap_q;
        result_d  = result_q;
        rd_d      = rd_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    op_d      = bus.funct3_i;
                    rd_cap_d  = bus.rd_i;
                    cnt_d     = 5'd0;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    hi_d      = '0;
                    if (div_zero) begin
                        result_d = bus.funct3_i[1] ? bus.rs1_i : 32'hFFFF_FFFF;
                        rd_d     = bus.rd_i;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = bus.funct3_i[1] ? 32'd0 : 32'h8000_0000;
                        rd_d     = bus.rd_i;
                        state_d  = S_DONE;
                    end else begin
                        // Multiply adds |rs1| into the product as |rs2| shifts out;
                        // divide shifts |rs1| into the remainder against |rs2|.
                        opb_d   = is_div ? b_mag : a_mag;
                        lo_d    = is_div ? a_mag : b_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d  = op_q[2] ? div_hi : mul_hi;
                lo_d  = op_q[2] ? div_lo : mul_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = final_res;
                    rd_d     = rd_cap_q;
                    cnt_d    = 5'd0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            rd_cap_q  <= 5'd0;
            result_q  <= '0;
            rd_q      <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            rd_cap_q  <= rd_cap_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    assign bus.busy_o   = (state_q == S_CALC);
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_q;
    assign bus.state_o  = state_q;

endmodule
